multicycle_control: RTL

//  Moore FSM sequencing the shared datapath (PC, IR, regfile, ALU, immediate extender, memory) one instruction at a time.

---
 rtl/mc_ctrl_pkg.sv | 89 ++++++++
 rtl/mc_op_decode.sv | 60 ++++++
 rtl/multicycle_control.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding, opcode constants,
// ALU operation codes, PC / ALU-B source codes, instruction class encoding and the bundled
// control-word struct driven onto the datapath.
// Optional feature macro used by the controller: MC_CTRL_WAIT_EN (memory wait states).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump
    } state_e;

    typedef enum logic [2:0] {
        ClsLoad,
        ClsStore,
        ClsR,
        ClsBranch,
        ClsJump,
        ClsImm,
        ClsIllegal
    } op_class_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // ALU operation codes
    localparam logic [2:0] AluAdd   = 3'd0;
    localparam logic [2:0] AluSub   = 3'd1;
    localparam logic [2:0] AluFunct = 3'd2;
    localparam logic [2:0] AluSlt   = 3'd3;
    localparam logic [2:0] AluSltu  = 3'd4;
    localparam logic [2:0] AluAnd   = 3'd5;
    localparam logic [2:0] AluOr    = 3'd6;
    localparam logic [2:0] AluXor   = 3'd7;

    // PC source select
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    // ALU B operand select
    localparam logic [1:0] SrcBReg   = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] SrcBImmSh = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_unsigned;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_err;
    } ctrl_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder for the multi-cycle controller.
// Ports:
//   op_i            opcode to classify
//   op_class_o      instruction class (load/store/R/branch/jump/immediate/illegal)
//   imm_alu_op_o    ALU operation for immediate-class instructions (add otherwise)
//   ext_unsigned_o  1 = zero-extend immediate (andi/ori/xori), 0 = sign-extend
//   legal_o         opcode is supported
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output op_class_e  op_class_o,
    output logic [2:0] imm_alu_op_o,
    output logic       ext_unsigned_o,
    output logic       legal_o
);

    always_comb begin
        op_class_o     = ClsIllegal;
        imm_alu_op_o   = AluAdd;
        ext_unsigned_o = 1'b0;
        unique case (op_i)
            OpLw:    op_class_o = ClsLoad;
            OpSw:    op_class_o = ClsStore;
            OpRType: op_class_o = ClsR;
            OpBeq,
            OpBne:   op_class_o = ClsBranch;
            OpJ:     op_class_o = ClsJump;
            OpAddi,
            OpAddiu: op_class_o = ClsImm;
            OpSlti: begin
                op_class_o   = ClsImm;
                imm_alu_op_o = AluSlt;
            end
            OpSltiu: begin
                op_class_o   = ClsImm;
                imm_alu_op_o = AluSltu;
            end
            OpAndi: begin
                op_class_o     = ClsImm;
                imm_alu_op_o   = AluAnd;
                ext_unsigned_o = 1'b1;
            end
            OpOri: begin
                op_class_o     = ClsImm;
                imm_alu_op_o   = AluOr;
                ext_unsigned_o = 1'b1;
            end
            OpXori: begin
                op_class_o     = ClsImm;
                imm_alu_op_o   = AluXor;
                ext_unsigned_o = 1'b1;
            end
            default: op_class_o = ClsIllegal;
        endcase
    end

    assign legal_o = (op_class_o != ClsIllegal);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore controller: sequences FETCH/DECODE/execute states and drives every
// datapath select and strobe. Outputs decode from the current state and the latched opcode
// (op_q); the live opcode is only consulted in DECODE for dispatch and the illegal_op pulse.
// Optional macro MC_CTRL_WAIT_EN: memory states stall on mem_ready and time out after
// TIMEOUT consecutive low cycles with a bus_err pulse.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode, funct     IR fields (funct is decoded by the ALU, not here)
//   zero              ALU zero flag (consumed by the PC logic via pc_write_cond/branch_ne)
//   mem_ready         memory completion (wait-state build only)
//   pc_write .. bus_err  datapath control strobes and status pulses
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       ext_unsigned,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;

    // Decode of the live opcode: used only for DECODE dispatch
    op_class_e  in_class;
    logic       in_legal;
    logic [2:0] unused_in_alu_op;
    logic       unused_in_ext;

    // Decode of the latched opcode: drives execute-phase selects
    op_class_e  q_class;
    logic [2:0] q_alu_op;
    logic       q_ext;
    logic       unused_q_legal;

    mc_op_decode u_in_decode (
        .op_i           (opcode),
        .op_class_o     (in_class),
        .imm_alu_op_o   (unused_in_alu_op),
        .ext_unsigned_o (unused_in_ext),
        .legal_o        (in_legal)
    );

    mc_op_decode u_q_decode (
        .op_i           (op_q),
        .op_class_o     (q_class),
        .imm_alu_op_o   (q_alu_op),
        .ext_unsigned_o (q_ext),
        .legal_o        (unused_q_legal)
    );

    logic stall;
    logic timeout;

`ifdef MC_CTRL_WAIT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_state;

    assign mem_state = (state_q == StFetch) || (state_q == StMemRead) ||
                       (state_q == StMemWrite);
    assign stall     = mem_state && !mem_ready;
    // The TIMEOUT-th consecutive low cycle is the one that raises bus_err
    assign timeout   = stall && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (timeout || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if (stall) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    logic unused_sig;
    assign unused_sig = ^{funct, zero, unused_in_alu_op, unused_in_ext, unused_q_legal};
`else
    assign stall   = 1'b0;
    assign timeout = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{funct, zero, mem_ready, unused_in_alu_op, unused_in_ext,
                          unused_q_legal, (TIMEOUT == 0)};
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StFetch: begin
                if (!stall) state_d = StDecode;
            end
            StDecode: begin
                op_d = opcode;
                unique case (in_class)
                    ClsLoad,
                    ClsStore:  state_d = StMemAddr;
                    ClsR:      state_d = StRExec;
                    ClsBranch: state_d = StBranch;
                    ClsJump:   state_d = StJump;
                    ClsImm:    state_d = StIExec;
                    default:   state_d = StFetch;
                endcase
            end
            StMemAddr:  state_d = (q_class == ClsStore) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (!stall) state_d = StMemWb;
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (!stall) state_d = StFetch;
            end
            StRExec:    state_d = StRWb;
            StRWb:      state_d = StFetch;
            StIExec:    state_d = StIWb;
            StIWb:      state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
            default:    state_d = StFetch;
        endcase
        // Timeout abandons the instruction without any PC or register update
        if (timeout) state_d = StFetch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            op_q       <= '0;
`ifdef MC_CTRL_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
`ifdef MC_CTRL_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Moore output decode; forced to zero while reset is asserted so that an aborted
    // instruction issues no strobes in the reset cycle.
    ctrl_t ctrl;

    always_comb begin
        ctrl              = '0;
        ctrl.ext_unsigned = q_ext;
        unique case (state_q)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = !stall;
                ctrl.pc_write  = !stall;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluAdd;
            end
            StDecode: begin
                ctrl.alu_src_b  = SrcBImmSh;
                ctrl.alu_op     = AluAdd;
                ctrl.illegal_op = !in_legal;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluAdd;
            end
            StMemRead: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = !stall;
            end
            StRExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = AluFunct;
            end
            StRWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StIExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = q_alu_op;
            end
            StIWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SrcBReg;
                ctrl.alu_op        = AluSub;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PcSrcAluOut;
                ctrl.branch_ne     = (op_q == OpBne);
                ctrl.instr_done    = 1'b1;
            end
            StJump: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PcSrcJump;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        ctrl.bus_err = timeout;
        if (reset) ctrl = '0;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign ext_unsigned  = ctrl.ext_unsigned;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign bus_err       = ctrl.bus_err;

endmodule
